serial_pattern_tx: RTL and testbench

Bit-serial pattern transmitter: accepts a parallel pattern word with a bit length and repeat count, then drives it out MSB-first, one bit per clock, as a Moore-style registered stream. It is the transmit-side counterpart of the team's serial sequence detectors. It produces the `d_in` bitstream those detectors consume, both for on-chip stimulus and loopback self-test.

---
 rtl/serial_pattern_tx.sv | 127 ++++++++++++
 tb/tb_serial_pattern_tx.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Bit-serial pattern transmitter: sends the low `len` bits of a captured word MSB-first,
// repeated `repeat_cnt`+1 times, as a registered d_out/d_valid stream.
module serial_pattern_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] repeat_cnt,
    output logic             ready,
    output logic             d_out,
    output logic             d_valid,
    output logic             done,
    output logic             err
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [REP_W-1:0]   pass_q, pass_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic               ready_d, d_out_d, d_valid_d, done_d, err_d;

    logic               len_ok;
    logic [IDX_W-1:0]   len_m1;

    assign len_ok = (len != '0) && (len <= LEN_W'(WIDTH));
    assign len_m1 = IDX_W'(len - LEN_W'(1));

    // State, counters, captured data and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            pass_q  <= '0;
            pat_q   <= '0;
            ready   <= 1'b1;
            d_out   <= 1'b0;
            d_valid <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            pass_q  <= pass_d;
            pat_q   <= pat_d;
            ready   <= ready_d;
            d_out   <= d_out_d;
            d_valid <= d_valid_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    // Next state; the output values computed here appear on the ports one cycle later
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        pass_d    = pass_q;
        pat_d     = pat_q;
        ready_d   = 1'b0;
        d_out_d   = 1'b0;
        d_valid_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    if (len_ok) begin
                        pat_d     = pattern;
                        last_d    = len_m1;
                        idx_d     = len_m1;
                        pass_d    = repeat_cnt;
                        state_d   = SHIFT;
                        ready_d   = 1'b0;
                        d_valid_d = 1'b1;
                        d_out_d   = pattern[len_m1];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                // idx_q is the bit currently on d_out; decide what follows it
                if (idx_q != '0) begin
                    idx_d     = idx_q - IDX_W'(1);
                    d_valid_d = 1'b1;
                    d_out_d   = pat_q[idx_d];
                end else if (pass_q != '0) begin
                    pass_d    = pass_q - REP_W'(1);
                    idx_d     = last_q;
                    d_valid_d = 1'b1;
                    d_out_d   = pat_q[last_q];
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed scenarios plus randomized transfers
// compared against a bit-queue reference model.
module tb_serial_pattern_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned REP_W = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] repeat_cnt;
    logic             ready;
    logic             d_out;
    logic             d_valid;
    logic             done;
    logic             err;

    int compared;
    int mismatched;

    serial_pattern_tx #(
        .WIDTH(WIDTH),
        .LEN_W(LEN_W),
        .REP_W(REP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .repeat_cnt(repeat_cnt),
        .ready     (ready),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance into the next cycle; outputs are stable and inputs may be changed here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        compared++;
        if (ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s wait_ready: ready=%b after %0d cycles, required 1", tag, ready, n);
        end
    endtask

    // Expected bitstream: (rep+1) passes of bits len-1 down to 0
    task automatic build_model(input logic [WIDTH-1:0] p, input int l, input int r,
                               output bit q[$]);
        q = {};
        for (int pass = 0; pass <= r; pass++)
            for (int i = l - 1; i >= 0; i--)
                q.push_back(bit'((p >> i) & 1));
    endtask

    // Launches one transfer and checks its whole stream; optionally disturbs inputs mid-stream
    task automatic run_transfer(input string tag, input logic [WIDTH-1:0] p, input int l,
                                input int r, input bit disturb, output int det101);
        bit q[$];
        logic [2:0] hist;
        build_model(p, l, r, q);
        det101 = 0;
        hist = 3'b000;
        wait_ready(tag);
        pattern    = p;
        len        = LEN_W'(l);
        repeat_cnt = REP_W'(r);
        start      = 1'b1;
        tick();
        start = 1'b0;
        compared++;
        if (ready !== 1'b0) begin
            mismatched++;
            $display("FAIL %s accept_ready: ready=%b, required 0", tag, ready);
        end
        for (int k = 0; k < q.size(); k++) begin
            compared++;
            if (d_valid !== 1'b1 || d_out !== q[k] || done !== 1'b0 || err !== 1'b0) begin
                mismatched++;
                $display("FAIL %s bit%0d: valid=%b d_out=%b done=%b err=%b, required 1 %b 0 0",
                         tag, k, d_valid, d_out, done, err, q[k]);
            end
            hist = {hist[1:0], d_out};
            if (k >= 2 && hist == 3'b101) det101++;
            if (disturb && k == 1) begin
                start      = 1'b1;
                pattern    = ~p;
                len        = LEN_W'($urandom_range(1, WIDTH));
                repeat_cnt = REP_W'($urandom_range(0, 3));
            end
            if (disturb && k == 3) start = 1'b0;
            tick();
        end
        start = 1'b0;
        compared++;
        if (done !== 1'b1 || d_valid !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL %s done_cycle: done=%b valid=%b ready=%b err=%b, required 1 0 0 0",
                     tag, done, d_valid, ready, err);
        end
        tick();
        compared++;
        if (ready !== 1'b1 || done !== 1'b0 || d_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL %s ready_return: ready=%b done=%b valid=%b, required 1 0 0",
                     tag, ready, done, d_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        pattern = '0;
        len = '0;
        repeat_cnt = '0;
        #2;
        compared++;
        if ({ready, d_out, d_valid, done, err} !== 5'b10000) begin
            mismatched++;
            $display("FAIL reset_hold: rdy/out/vld/done/err=%b, required 10000",
                     {ready, d_out, d_valid, done, err});
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        compared++;
        if ({ready, d_out, d_valid, done, err} !== 5'b10000) begin
            mismatched++;
            $display("FAIL reset_release: rdy/out/vld/done/err=%b, required 10000",
                     {ready, d_out, d_valid, done, err});
        end
    endtask

    task automatic test_single_pass();
        int det;
        run_transfer("single", 8'h05, 3, 0, 1'b0, det);
        compared++;
        if (det !== 1) begin
            mismatched++;
            $display("FAIL single_detect101: count=%0d, required 1", det);
        end
    endtask

    task automatic test_full_repeat();
        int det;
        run_transfer("full_rep", 8'hB2, 8, 2, 1'b0, det);
    endtask

    task automatic test_illegal_len();
        int bad[2] = '{0, 9};
        wait_ready("illegal");
        for (int i = 0; i < 2; i++) begin
            len   = LEN_W'(bad[i]);
            start = 1'b1;
            tick();
            start = 1'b0;
            compared++;
            if (err !== 1'b1 || ready !== 1'b1 || d_valid !== 1'b0 || done !== 1'b0) begin
                mismatched++;
                $display("FAIL illegal_len%0d_pulse: err=%b ready=%b valid=%b done=%b, required 1 1 0 0",
                         bad[i], err, ready, d_valid, done);
            end
            tick();
            compared++;
            if (err !== 1'b0 || ready !== 1'b1 || d_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL illegal_len%0d_after: err=%b ready=%b valid=%b, required 0 1 0",
                         bad[i], err, ready, d_valid);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        int det;
        run_transfer("ignored", 8'hC6, 6, 1, 1'b1, det);
        tick();
        compared++;
        if (d_valid !== 1'b0 || ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ignored_no_second: valid=%b ready=%b, required 0 1", d_valid, ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] p;
        logic exp_bit;
        p = WIDTH'($urandom);
        wait_ready("b2b");
        pattern    = p;
        len        = LEN_W'(2);
        repeat_cnt = '0;
        start      = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            case (c % 4)
                0, 1: begin
                    exp_bit = p[1 - (c % 4)];
                    compared++;
                    if (d_valid !== 1'b1 || d_out !== exp_bit || ready !== 1'b0) begin
                        mismatched++;
                        $display("FAIL b2b_c%0d_bit: valid=%b d_out=%b ready=%b, required 1 %b 0",
                                 c, d_valid, d_out, ready, exp_bit);
                    end
                end
                2: begin
                    compared++;
                    if (done !== 1'b1 || d_valid !== 1'b0) begin
                        mismatched++;
                        $display("FAIL b2b_c%0d_done: done=%b valid=%b, required 1 0", c, done, d_valid);
                    end
                end
                default: begin
                    compared++;
                    if (ready !== 1'b1 || d_valid !== 1'b0 || done !== 1'b0) begin
                        mismatched++;
                        $display("FAIL b2b_c%0d_accept: ready=%b valid=%b done=%b, required 1 0 0",
                                 c, ready, d_valid, done);
                    end
                end
            endcase
        end
        start = 1'b0;
        tick();
        compared++;
        if (ready !== 1'b1 || d_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_stop: ready=%b valid=%b, required 1 0", ready, d_valid);
        end
    endtask

    task automatic test_reset_mid();
        int det;
        wait_ready("rst_mid");
        pattern    = 8'hFF;
        len        = LEN_W'(8);
        repeat_cnt = '0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        compared++;
        if (d_valid !== 1'b0 || d_out !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_async: valid=%b d_out=%b ready=%b done=%b, required 0 0 1 0",
                     d_valid, d_out, ready, done);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            compared++;
            if (d_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
                mismatched++;
                $display("FAIL rst_mid_idle%0d: valid=%b done=%b ready=%b, required 0 0 1",
                         c, d_valid, done, ready);
            end
        end
        run_transfer("rst_mid_new", 8'h5A, 8, 0, 1'b0, det);
    endtask

    task automatic test_random();
        int det, l, r;
        logic [WIDTH-1:0] p;
        for (int t = 0; t < 25; t++) begin
            p = WIDTH'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(WIDTH + 1, 15);
                wait_ready("rand_bad");
                len   = LEN_W'(l);
                start = 1'b1;
                tick();
                start = 1'b0;
                compared++;
                if (err !== 1'b1 || d_valid !== 1'b0 || ready !== 1'b1) begin
                    mismatched++;
                    $display("FAIL rand%0d_illegal len=%0d: err=%b valid=%b ready=%b, required 1 0 1",
                             t, l, err, d_valid, ready);
                end
                tick();
            end else begin
                l = $urandom_range(1, WIDTH);
                r = $urandom_range(0, 4);
                run_transfer($sformatf("rand%0d_p%02h_l%0d_r%0d", t, p, l, r), p, l, r, 1'b0, det);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_single_pass();
        test_full_repeat();
        test_illegal_len();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // done and err must never coincide
    always @(negedge clk) begin
        if (!reset) begin
            compared++;
            if (done === 1'b1 && err === 1'b1) begin
                mismatched++;
                $display("FAIL done_err_overlap: done=%b err=%b, required not both 1", done, err);
            end
        end
    end

endmodule
